// File: rtl/uart_card_sequencer.sv
// UART-to-card command sequencer: parses host 'W'/'R' block commands, drives the card
// write/read channels, streams block data through and returns one status byte per command.
module uart_card_sequencer #(
    parameter int unsigned BLOCK_BYTES  = 512,
    parameter logic [7:0]  CMD_WR       = 8'h57,
    parameter logic [7:0]  CMD_RD       = 8'h52,
    parameter int unsigned ADDR_TIMEOUT = 5000000
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    // UART RX
    input  logic        RX_STB,
    input  logic [7:0]  RX_DAT,
    output logic        RX_ACK,
    // UART TX
    output logic        TX_STB,
    output logic [7:0]  TX_DAT,
    input  logic        TX_ACK,
    // card block-write command
    output logic        WR_STB,
    output logic [31:0] WR_ADDR,
    input  logic        WR_ACK,
    // card write-data stream
    output logic        WD_STB,
    output logic [7:0]  WD_DATA,
    input  logic        WD_ACK,
    // card block-read command
    output logic        RD_STB,
    output logic [31:0] RD_ADDR,
    input  logic        RD_ACK,
    // card read-data stream
    input  logic        RES_STB,
    input  logic [7:0]  RES_DATA,
    output logic        RES_ACK,
    output logic        BUSY
);

    localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TW = $clog2(ADDR_TIMEOUT + 1);

    localparam logic [7:0] ST_BAD_CMD = 8'h3F;
    localparam logic [7:0] ST_TIMEOUT = 8'h54;
    localparam logic [7:0] ST_OK      = 8'h4B;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrCmd,
        StWrData,
        StRdCmd,
        StRdData,
        StStatus
    } state_t;

    state_t        state_q, state_d;
    logic          op_wr_q, op_wr_d;      // 1: write command, 0: read command
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    abyte_q, abyte_d;      // address bytes received so far
    logic [TW-1:0] idle_q, idle_d;        // idle cycles since last address byte
    logic [CW-1:0] cnt_q, cnt_d;          // data bytes transferred in the block
    logic [7:0]    status_q, status_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK50) begin
        if (RESET) begin
            state_q  <= StIdle;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            abyte_q  <= '0;
            idle_q   <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            abyte_q  <= abyte_d;
            idle_q   <= idle_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    // Next-state logic and per-state channel muxing.
    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        abyte_d  = abyte_q;
        idle_d   = idle_q;
        cnt_d    = cnt_q;
        status_d = status_q;

        RX_ACK   = 1'b0;
        TX_STB   = 1'b0;
        TX_DAT   = 8'h00;
        WR_STB   = 1'b0;
        WD_STB   = 1'b0;
        WD_DATA  = 8'h00;
        RD_STB   = 1'b0;
        RES_ACK  = 1'b0;

        unique case (state_q)
            StIdle: begin
                RX_ACK = RX_STB;
                if (RX_STB) begin
                    if (RX_DAT == CMD_WR || RX_DAT == CMD_RD) begin
                        op_wr_d = (RX_DAT == CMD_WR);
                        abyte_d = '0;
                        idle_d  = '0;
                        state_d = StAddr;
                    end else begin
                        status_d = ST_BAD_CMD;
                        state_d  = StStatus;
                    end
                end
            end
            StAddr: begin
                RX_ACK = RX_STB;
                if (RX_STB) begin
                    // Shift in MSB first; four shifts fully replace the old address.
                    addr_d  = {addr_q[23:0], RX_DAT};
                    abyte_d = abyte_q + 2'd1;
                    idle_d  = '0;
                    if (abyte_q == 2'd3) begin
                        state_d = op_wr_q ? StWrCmd : StRdCmd;
                    end
                end else if (idle_q == TW'(ADDR_TIMEOUT - 1)) begin
                    status_d = ST_TIMEOUT;
                    state_d  = StStatus;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StWrCmd: begin
                WR_STB = 1'b1;
                if (WR_ACK) begin
                    cnt_d   = '0;
                    state_d = StWrData;
                end
            end
            StWrData: begin
                WD_STB  = RX_STB;
                WD_DATA = RX_DAT;
                RX_ACK  = WD_ACK;
                if (RX_STB && WD_ACK) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        status_d = ST_OK;
                        state_d  = StStatus;
                    end
                end
            end
            StRdCmd: begin
                RD_STB = 1'b1;
                if (RD_ACK) begin
                    cnt_d   = '0;
                    state_d = StRdData;
                end
            end
            StRdData: begin
                TX_STB  = RES_STB;
                TX_DAT  = RES_DATA;
                RES_ACK = TX_ACK;
                if (RES_STB && TX_ACK) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        status_d = ST_OK;
                        state_d  = StStatus;
                    end
                end
            end
            StStatus: begin
                TX_STB = 1'b1;
                TX_DAT = status_q;
                if (TX_ACK) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // One address register serves both command channels.
    always_comb begin
        WR_ADDR = addr_q;
        RD_ADDR = addr_q;
        BUSY    = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_card_sequencer.sv
// Self-checking bench for uart_card_sequencer: table of host commands plus hand-written
// timeout, TX back-pressure and mid-command reset sequences.
module tb_uart_card_sequencer;

    localparam int BB = 512;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_stb, rx_ack, tx_stb, tx_ack;
    logic [7:0]  rx_dat, tx_dat, wd_data, res_data;
    logic        wr_stb, wr_ack, wd_stb, wd_ack, rd_stb, rd_ack, res_stb, res_ack, busy;
    logic [31:0] wr_addr, rd_addr;

    always #5 clk = ~clk;

    uart_card_sequencer #(
        .BLOCK_BYTES (BB),
        .CMD_WR      (8'h57),
        .CMD_RD      (8'h52),
        .ADDR_TIMEOUT(TO)
    ) dut (
        .CLOCK50 (clk),
        .RESET   (rst),
        .RX_STB  (rx_stb),
        .RX_DAT  (rx_dat),
        .RX_ACK  (rx_ack),
        .TX_STB  (tx_stb),
        .TX_DAT  (tx_dat),
        .TX_ACK  (tx_ack),
        .WR_STB  (wr_stb),
        .WR_ADDR (wr_addr),
        .WR_ACK  (wr_ack),
        .WD_STB  (wd_stb),
        .WD_DATA (wd_data),
        .WD_ACK  (wd_ack),
        .RD_STB  (rd_stb),
        .RD_ADDR (rd_addr),
        .RD_ACK  (rd_ack),
        .RES_STB (res_stb),
        .RES_DATA(res_data),
        .RES_ACK (res_ack),
        .BUSY    (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observed traffic, sampled mid-cycle at the falling edge.
    logic [7:0]  wd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  res_src[$];
    int          wr_hs_n, rd_hs_n;
    logic [31:0] wr_addr_seen, rd_addr_seen;
    bit          wr_stb_seen, res_hs, rd_hs_flag, tx_hold;

    initial begin
        wr_hs_n = 0; rd_hs_n = 0; wr_stb_seen = 0; res_hs = 0; rd_hs_flag = 0;
        wr_addr_seen = '0; rd_addr_seen = '0;
        forever begin
            @(negedge clk);
            res_hs     = res_stb && res_ack;
            rd_hs_flag = rd_stb && rd_ack;
            if (wr_stb) wr_stb_seen = 1;
            if (wr_stb && wr_ack) begin wr_hs_n++; wr_addr_seen = wr_addr; end
            if (rd_stb && rd_ack) begin rd_hs_n++; rd_addr_seen = rd_addr; end
            if (wd_stb && wd_ack) wd_q.push_back(wd_data);
            if (tx_stb && tx_ack) tx_q.push_back(tx_dat);
        end
    end

    // Card and UART-TX models; inputs change 1 time unit after the rising edge.
    initial begin
        wr_ack = 0; rd_ack = 0; wd_ack = 0; tx_ack = 0; res_stb = 0; res_data = 0;
        tx_hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                res_src.delete();
                wr_ack = 0; rd_ack = 0; res_stb = 0; res_data = 0;
            end else begin
                wr_ack = wr_stb && !wr_ack;
                rd_ack = rd_stb && !rd_ack;
                if (res_hs && res_src.size() > 0) void'(res_src.pop_front());
                if (rd_hs_flag)
                    for (int i = 0; i < BB; i++)
                        res_src.push_back(8'(i * 7 + int'(rd_addr_seen[7:0])));
                res_stb  = (res_src.size() > 0);
                res_data = (res_src.size() > 0) ? res_src[0] : 8'h00;
            end
            wd_ack = ($urandom_range(3) != 0);
            tx_ack = tx_hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    function automatic logic [7:0] txb(input int i);
        return (tx_q.size() > i) ? tx_q[i] : 8'hxx;
    endfunction

    // Called and returns 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_stb = 1; rx_dat = b;
        @(negedge clk);
        while (!rx_ack && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ack) begin
            checks++; errors++;
            $display("FAIL rx_accept: byte %0h got no RX_ACK, expected one within 1000 cycles", b);
        end
        @(posedge clk);
        #1;
        rx_stb = 0;
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int c = 0;
        while (tx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, tx_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wd_q.delete(); tx_q.delete();
        wr_hs_n = 0; rd_hs_n = 0; wr_stb_seen = 0;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        int          kind;       // 0 write, 1 read, 2 unknown opcode
        logic [7:0]  exp_status;
    } vec_t;

    vec_t vecs[7];

    task automatic run_cmd(input vec_t v);
        int bad;
        clear_obs();
        send_byte(v.op);
        if (v.kind != 2) begin
            for (int k = 0; k < 4; k++) send_byte(v.addr[31 - 8 * k -: 8]);
            if (v.kind == 0) check("wr_stb_latency", wr_stb, 1);
            else             check("rd_stb_latency", rd_stb, 1);
        end
        if (v.kind == 0) begin
            for (int i = 0; i < BB; i++) send_byte(8'(i));
            wait_tx(1, 200, "wr_status_count");
            check("wr_status", txb(0), v.exp_status);
            check("wr_handshakes", wr_hs_n, 1);
            check("wr_addr", wr_addr_seen, v.addr);
            bad = 0;
            for (int i = 0; i < BB; i++)
                if (i >= wd_q.size() || wd_q[i] !== 8'(i)) bad++;
            check("wd_count", wd_q.size(), BB);
            check("wd_order_errors", bad, 0);
        end else if (v.kind == 1) begin
            wait_tx(BB + 1, 5000, "rd_tx_count");
            check("rd_handshakes", rd_hs_n, 1);
            check("rd_addr", rd_addr_seen, v.addr);
            bad = 0;
            for (int i = 0; i < BB; i++)
                if (txb(i) !== 8'(i * 7 + int'(v.addr[7:0]))) bad++;
            check("rd_order_errors", bad, 0);
            check("rd_status", txb(BB), v.exp_status);
        end else begin
            wait_tx(1, 100, "bad_status_count");
            check("bad_status", txb(0), v.exp_status);
            check("bad_no_card_cmd", wr_hs_n + rd_hs_n, 0);
        end
        check("busy_after", busy, 0);
    endtask

    initial begin
        int   c;
        logic [7:0] held;
        int   sz0, hold_bad;

        vecs[0] = '{8'h57, 32'h0000_0102, 0, 8'h4B};
        vecs[1] = '{8'h52, 32'hDEAD_BEEF, 1, 8'h4B};
        vecs[2] = '{8'h41, 32'h0,         2, 8'h3F};
        vecs[3] = '{8'h52, 32'h1234_5678, 1, 8'h4B};
        vecs[4] = '{8'h57, 32'hFFFF_FFFF, 0, 8'h4B};
        vecs[5] = '{8'h00, 32'h0,         2, 8'h3F};
        vecs[6] = '{8'h52, 32'h0000_0000, 1, 8'h4B};

        rst = 1; rx_stb = 0; rx_dat = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_outputs", {rx_ack, tx_stb, tx_dat, wr_stb, wr_addr, wd_stb, wd_data,
                                rd_stb, rd_addr, res_ack, busy} == '0, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // Address timeout: 'W' plus one address byte, then silence.
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h00);
        c = 0;
        while (tx_q.size() == 0 && c < TO + 200) begin
            @(negedge clk);
            c++;
        end
        check("timeout_window", (c >= TO) && (c <= TO + 30), 1);
        check("timeout_status", txb(0), 8'h54);
        @(posedge clk);
        #1;
        check("timeout_no_wr_stb", wr_stb_seen, 0);
        check("timeout_busy", busy, 0);

        // TX back-pressure mid read stream.
        clear_obs();
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
        wait_tx(200, 2000, "hold_pre_count");
        tx_hold = 1;
        @(negedge clk);
        @(negedge clk);
        held = tx_dat;
        sz0 = tx_q.size();
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (res_ack !== 1'b0 || tx_stb !== 1'b1 || tx_dat !== held) hold_bad++;
            @(negedge clk);
        end
        check("hold_stable_errors", hold_bad, 0);
        check("hold_no_transfer", tx_q.size(), sz0);
        @(posedge clk);
        #1 tx_hold = 0;
        wait_tx(BB + 1, 5000, "hold_tx_count");
        hold_bad = 0;
        for (int i = 0; i < BB; i++)
            if (txb(i) !== 8'(i * 7 + 'hCD)) hold_bad++;
        check("hold_order_errors", hold_bad, 0);
        check("hold_status", txb(BB), 8'h4B);

        // Reset after 100 write-data bytes, then a clean write.
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        check("partial_wd_count", wd_q.size(), 100);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("midreset_outputs", {rx_ack, tx_stb, tx_dat, wr_stb, wr_addr, wd_stb, wd_data,
                                   rd_stb, rd_addr, res_ack, busy} == '0, 1);
        check("midreset_no_status", tx_q.size(), 0);
        @(posedge clk);
        #1;
        run_cmd(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
